// File: rtl/alu_div_sequencer_if.sv
// rtl/alu_div_sequencer_if.sv - Divider request/response and shared add/sub ALU signal bundle.
// SIGNED_DIV_EN adds the sign_en request bit.
interface alu_div_sequencer_if #(
  parameter int n = 32
);
  logic         start;
  logic [n-1:0] dividend;
  logic [n-1:0] divisor;
`ifdef SIGNED_DIV_EN
  logic         sign_en;
`endif
  logic         busy;
  logic         done;
  logic         dz_err;
  logic [n-1:0] quotient;
  logic [n-1:0] remainder;
  logic [n-1:0] alu_a;
  logic [n-1:0] alu_b;
  logic         alu_ctrl;
  logic [n-1:0] alu_y;
  logic         alu_cb;

`ifdef SIGNED_DIV_EN
  modport slave (
    input  start, dividend, divisor, sign_en, alu_y, alu_cb,
    output busy, done, dz_err, quotient, remainder, alu_a, alu_b, alu_ctrl
  );
  modport master (
    output start, dividend, divisor, sign_en, alu_y, alu_cb,
    input  busy, done, dz_err, quotient, remainder, alu_a, alu_b, alu_ctrl
  );
`else
  modport slave (
    input  start, dividend, divisor, alu_y, alu_cb,
    output busy, done, dz_err, quotient, remainder, alu_a, alu_b, alu_ctrl
  );
  modport master (
    output start, dividend, divisor, alu_y, alu_cb,
    input  busy, done, dz_err, quotient, remainder, alu_a, alu_b, alu_ctrl
  );
`endif
endinterface

// File: rtl/alu_div_sequencer.sv
// rtl/alu_div_sequencer.sv - Restoring divider sequencer that borrows the shared add/sub ALU.
// Define SIGNED_DIV_EN for the sign_en input and the FIX sign-correction state.
module alu_div_sequencer #(
  parameter int n = 32
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  alu_div_sequencer_if.slave bus
);
  localparam int CW = $clog2(n);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
`ifdef SIGNED_DIV_EN
    , S_FIX
`endif
  } state_t;

  state_t        r_state;
  logic [n-1:0]  r_q;
  logic [n-1:0]  r_rem;
  logic [n-1:0]  r_d;
  logic [CW-1:0] r_cnt;
  logic          r_busy;
  logic          r_done;
  logic          r_dz_err;
  logic          r_alu_ctrl;
  logic [n-1:0]  r_quotient;
  logic [n-1:0]  r_remainder;
`ifdef SIGNED_DIV_EN
  logic          r_sign_en;
  logic          r_qneg;
  logic          r_rneg;
`endif

  logic [n:0]    w_sh;
  logic          w_sub_ok;
  logic [n-1:0]  w_rem_nx;
  logic [n-1:0]  w_q_nx;
  logic          w_last;
  logic [n-1:0]  w_dvd_in;
  logic [n-1:0]  w_dvs_in;
  logic          w_need_fix;

  // Shifted partial remainder keeps its carry-out bit: if set, it exceeds any n-bit divisor.
  assign w_sh     = {r_rem, r_q[n-1]};
  assign w_sub_ok = w_sh[n] | ~bus.alu_cb;
  assign w_rem_nx = w_sub_ok ? bus.alu_y : w_sh[n-1:0];
  assign w_q_nx   = {r_q[n-2:0], w_sub_ok};
  assign w_last   = (r_cnt == CW'(n - 1));

`ifdef SIGNED_DIV_EN
  function automatic logic [n-1:0] f_neg(input logic [n-1:0] x);
    return ~x + {{(n-1){1'b0}}, 1'b1};
  endfunction

  logic w_dvd_neg;
  logic w_dvs_neg;
  assign w_dvd_neg  = bus.sign_en & bus.dividend[n-1];
  assign w_dvs_neg  = bus.sign_en & bus.divisor[n-1];
  assign w_dvd_in   = w_dvd_neg ? f_neg(bus.dividend) : bus.dividend;
  assign w_dvs_in   = w_dvs_neg ? f_neg(bus.divisor) : bus.divisor;
  assign w_need_fix = r_sign_en;
`else
  assign w_dvd_in   = bus.dividend;
  assign w_dvs_in   = bus.divisor;
  assign w_need_fix = 1'b0;
`endif

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.dz_err    = r_dz_err;
  assign bus.quotient  = r_quotient;
  assign bus.remainder = r_remainder;
  assign bus.alu_a     = w_sh[n-1:0];
  assign bus.alu_b     = r_d;
  assign bus.alu_ctrl  = r_alu_ctrl;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_q         <= '0;
      r_rem       <= '0;
      r_d         <= '0;
      r_cnt       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_dz_err    <= 1'b0;
      r_alu_ctrl  <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
`ifdef SIGNED_DIV_EN
      r_sign_en   <= 1'b0;
      r_qneg      <= 1'b0;
      r_rneg      <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_q   <= w_dvd_in;
            r_d   <= w_dvs_in;
            r_rem <= '0;
            r_cnt <= '0;
`ifdef SIGNED_DIV_EN
            r_sign_en <= bus.sign_en;
            r_qneg    <= w_dvd_neg ^ w_dvs_neg;
            r_rneg    <= w_dvd_neg;
`endif
            if (bus.divisor == '0) begin
              // Divide-by-zero resolves on the accept edge without touching the ALU.
              r_state     <= S_DONE;
              r_done      <= 1'b1;
              r_dz_err    <= 1'b1;
              r_quotient  <= '1;
              r_remainder <= bus.dividend;
              r_busy      <= 1'b0;
              r_alu_ctrl  <= 1'b0;
            end else begin
              r_state    <= S_BUSY;
              r_busy     <= 1'b1;
              r_alu_ctrl <= 1'b1;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end

        S_BUSY: begin
          r_rem <= w_rem_nx;
          r_q   <= w_q_nx;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_alu_ctrl <= 1'b0;
            if (w_need_fix) begin
`ifdef SIGNED_DIV_EN
              r_state <= S_FIX;
`endif
            end else begin
              r_state     <= S_DONE;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
              r_dz_err    <= 1'b0;
              r_quotient  <= w_q_nx;
              r_remainder <= w_rem_nx;
            end
          end
        end

`ifdef SIGNED_DIV_EN
        S_FIX: begin
          r_state     <= S_DONE;
          r_busy      <= 1'b0;
          r_done      <= 1'b1;
          r_dz_err    <= 1'b0;
          r_quotient  <= r_qneg ? f_neg(r_q) : r_q;
          r_remainder <= r_rneg ? f_neg(r_rem) : r_rem;
        end
`endif

        default: begin
          r_state    <= S_IDLE;
          r_busy     <= 1'b0;
          r_alu_ctrl <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_div_sequencer.sv
// tb/tb_alu_div_sequencer.sv - Directed bench for alu_div_sequencer with a behavioural add/sub ALU.
// Define SIGNED_DIV_EN to also run the signed vectors.
module tb_alu_div_sequencer;
  localparam int N = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   lat;
  int   pulses;

  alu_div_sequencer_if #(.n(N)) bus ();

  alu_div_sequencer #(.n(N)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Shared ALU: the top result bit is carry in add mode and borrow in sub mode.
  logic [N:0] w_alu;
  assign w_alu      = bus.alu_ctrl ? ({1'b0, bus.alu_a} - {1'b0, bus.alu_b})
                                   : ({1'b0, bus.alu_a} + {1'b0, bus.alu_b});
  assign bus.alu_y  = w_alu[N-1:0];
  assign bus.alu_cb = w_alu[N];

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  // Presents a request for one accept edge; returns at the negedge just after that edge.
  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b);
    bus.dividend = a;
    bus.divisor  = b;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
  endtask

  // Counts negedges from the accept (first negedge after it = 1) until done is seen.
  task automatic wait_done(input int from, output int cycles);
    cycles = from;
    while (!bus.done && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
`ifdef SIGNED_DIV_EN
    bus.sign_en  = 1'b0;
`endif
    repeat (2) @(negedge clk);

    check_bit("rst_busy",     bus.busy,     1'b0);
    check_bit("rst_done",     bus.done,     1'b0);
    check_bit("rst_dz_err",   bus.dz_err,   1'b0);
    check_bit("rst_alu_ctrl", bus.alu_ctrl, 1'b0);
    check("rst_quotient",  bus.quotient,  32'h0);
    check("rst_remainder", bus.remainder, 32'h0);
    check("rst_alu_a",     bus.alu_a,     32'h0);
    check("rst_alu_b",     bus.alu_b,     32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(32'd100, 32'd7);
    wait_done(1, lat);
    check("lat_100_7", lat, 32'd33);
    check("q_100_7", bus.quotient, 32'd14);
    check("r_100_7", bus.remainder, 32'd2);
    check_bit("dz_100_7", bus.dz_err, 1'b0);
    check_bit("busy_at_done", bus.busy, 1'b0);
    @(negedge clk);
    check_bit("done_one_cycle", bus.done, 1'b0);
    check("q_held_idle", bus.quotient, 32'd14);

    issue(32'hFFFF_FFFF, 32'h8000_0000);
    wait_done(1, lat);
    check("q_max_msb", bus.quotient, 32'd1);
    check("r_max_msb", bus.remainder, 32'h7FFF_FFFF);
    @(negedge clk);

    issue(32'h1234, 32'h0);
    wait_done(1, lat);
    check("lat_dz", lat, 32'd1);
    check("q_dz", bus.quotient, 32'hFFFF_FFFF);
    check("r_dz", bus.remainder, 32'h1234);
    check_bit("dz_flag", bus.dz_err, 1'b1);
    @(negedge clk);
    check_bit("dz_done_drop", bus.done, 1'b0);
    check_bit("dz_flag_held", bus.dz_err, 1'b1);

    issue(32'd5, 32'd9);
    wait_done(1, lat);
    check("q_small", bus.quotient, 32'd0);
    check("r_small", bus.remainder, 32'd5);
    check_bit("dz_cleared", bus.dz_err, 1'b0);
    @(negedge clk);

    // Start during BUSY must be ignored and operands must stay latched.
    issue(32'd100, 32'd7);
    repeat (4) @(negedge clk);
    bus.dividend = 32'd50;
    bus.divisor  = 32'd5;
    bus.start    = 1'b1;
    check_bit("busy_mid", bus.busy, 1'b1);
    check_bit("alu_ctrl_mid", bus.alu_ctrl, 1'b1);
    check("alu_b_mid", bus.alu_b, 32'd7);
    check("r_stable_mid", bus.remainder, 32'd5);
    @(negedge clk);
    bus.start = 1'b0;
    check("alu_b_after_ign", bus.alu_b, 32'd7);
    wait_done(6, lat);
    check("lat_ignored", lat, 32'd33);
    check("q_ignored", bus.quotient, 32'd14);
    check("r_ignored", bus.remainder, 32'd2);

    issue(32'd50, 32'd5);
    wait_done(1, lat);
    check("lat_b2b", lat, 32'd33);
    check("q_b2b", bus.quotient, 32'd10);
    check("r_b2b", bus.remainder, 32'd0);
    @(negedge clk);

    // Reset in the middle of an operation aborts it with every output cleared.
    issue(32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_bit("abort_busy", bus.busy, 1'b0);
    check_bit("abort_done", bus.done, 1'b0);
    check_bit("abort_alu_ctrl", bus.alu_ctrl, 1'b0);
    check("abort_quotient", bus.quotient, 32'h0);
    check("abort_alu_a", bus.alu_a, 32'h0);
    check("abort_alu_b", bus.alu_b, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) pulses++;
    end
    check("abort_no_done", pulses, 32'd0);

    issue(32'd9, 32'd3);
    wait_done(1, lat);
    check("lat_after_abort", lat, 32'd33);
    check("q_after_abort", bus.quotient, 32'd3);
    check("r_after_abort", bus.remainder, 32'd0);
    @(negedge clk);

`ifdef SIGNED_DIV_EN
    bus.sign_en = 1'b1;
    issue(32'hFFFF_FFF9, 32'd2);
    wait_done(1, lat);
    check("lat_signed", lat, 32'd34);
    check("q_signed", bus.quotient, 32'hFFFF_FFFD);
    check("r_signed", bus.remainder, 32'hFFFF_FFFF);
    @(negedge clk);

    issue(32'd7, 32'hFFFF_FFFE);
    wait_done(1, lat);
    check("q_signed_negdiv", bus.quotient, 32'hFFFF_FFFD);
    check("r_signed_negdiv", bus.remainder, 32'd1);
    @(negedge clk);

    bus.sign_en = 1'b0;
    issue(32'hFFFF_FFF9, 32'd2);
    wait_done(1, lat);
    check("lat_unsigned_sel", lat, 32'd33);
    check("q_unsigned_sel", bus.quotient, 32'h7FFF_FFFC);
    check("r_unsigned_sel", bus.remainder, 32'd1);
    @(negedge clk);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
